// File: rtl/stolen_cdc_filter_array.sv
// Multi-channel async-input synchronizer: per-channel sync chain, stability filter
// and registered rise/fall pulses into the clk domain. Channels are independent.

module stolen_cdc_filter_lane #(
   parameter int   DEST_SYNC_FF  = 3,
   parameter int   FILTER_CYCLES = 2,
   parameter logic RST_BIT       = 1'b0
) (
   input  logic clk,
   input  logic reset_p,
   input  logic async_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int CW = (FILTER_CYCLES > 0) ? $clog2(FILTER_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES);

   (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE" *)
   logic [DEST_SYNC_FF-1:0] sync_q;

   logic          s;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          lvl_q, lvl_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;
   logic          upd;

   // Plain shift chain: nothing may sit between stages.
   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) sync_q <= {DEST_SYNC_FF{RST_BIT}};
      else         sync_q <= {sync_q[DEST_SYNC_FF-2:0], async_i};
   end

   assign s = sync_q[DEST_SYNC_FF-1];

   // New value must be seen FILTER_CYCLES+1 consecutive cycles; any match restarts the count.
   always_comb begin
      cnt_d = cnt_q;
      lvl_d = lvl_q;
      upd   = 1'b0;
      if (s == lvl_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         lvl_d = s;
         cnt_d = '0;
         upd   = 1'b1;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
      rise_d = upd &  s;
      fall_d = upd & ~s;
   end

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         cnt_q  <= '0;
         lvl_q  <= RST_BIT;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         lvl_q  <= lvl_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign level_o = lvl_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule

module stolen_cdc_filter_array #(
   parameter int                  CHANNELS      = 4,
   parameter int                  DEST_SYNC_FF  = 3,
   parameter int                  FILTER_CYCLES = 2,
   parameter logic [CHANNELS-1:0] RST_VAL       = '0
) (
   input  logic                clk,
   input  logic                reset_p,
   input  logic [CHANNELS-1:0] async_in,
   output logic [CHANNELS-1:0] level_out,
   output logic [CHANNELS-1:0] rise_pulse,
   output logic [CHANNELS-1:0] fall_pulse,
   output logic                change_any
);

   for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
      stolen_cdc_filter_lane #(
         .DEST_SYNC_FF (DEST_SYNC_FF),
         .FILTER_CYCLES(FILTER_CYCLES),
         .RST_BIT      (RST_VAL[g])
      ) u_lane (
         .clk    (clk),
         .reset_p(reset_p),
         .async_i(async_in[g]),
         .level_o(level_out[g]),
         .rise_o (rise_pulse[g]),
         .fall_o (fall_pulse[g])
      );
   end

   assign change_any = |(rise_pulse | fall_pulse);

endmodule
